product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of multiplier_16bit in the ODE datapath.
- Consumes a stream of 16-bit tagged fixed-point products plus their overflow flags, and sums one group of terms (e.g. h·k1 + h·k2 + … for a solver step).
- Emits the sum re-normalized into the same tagged format at the highest precision that fits.
- Carries an overflow flag with the same convention as the multiplier: out = 0 when overflow = 1.

Parameters:
- MAX_TERMS, 15: maximum products per group; the term counter saturates here.
- CNT_W, 4: term counter width; must satisfy 2^CNT_W > MAX_TERMS.
- ACC_W, 24: internal accumulator width; must be ≥ 20 + ceil(log2(MAX_TERMS+1)), so internal overflow is impossible.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data / in_overflow / in_last are valid.
- in_ready  output  1  block accepts a term this cycle.
- in_data  input  16  product; [15:13] = F (fraction bits 0..7), [12:0] = signed mantissa M; value = M / 2^F.
- in_overflow  input  1  multiplier overflow for this product.
- in_last  input  1  final term of the group.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_data  output  16  sum in tagged format.
- out_overflow  output  1  sum invalid (out_data = 0).
- term_count  output  CNT_W  terms accepted in the current group.

Behaviour:
- Reset: state = ACCUM, acc = 0, sticky_ovf = 0, term_count = 0, out_valid = 0, out_data = 0, out_overflow = 0. in_ready = 1 after reset.
- Reset mid-group or while out_valid is high discards all state; no result is emitted.
- Alignment: each term is converted to a fixed 7-fraction-bit scale. aligned = sign_extend(M) <<< (7 − F), extended to ACC_W bits. acc is a signed ACC_W-bit register.

FSM states:
- ACCUM:
  - in_ready = 1.
  - On in_valid & in_ready: acc += aligned; sticky_ovf |= in_overflow; term_count increments (saturating).
  - If the accepted term brings the count past MAX_TERMS, sticky_ovf is set.
  - If in_last is set, go to NORM next cycle.
  - A term with in_last is accumulated in the same cycle it is accepted.
- NORM:
  - in_ready = 0; takes one cycle.
  - Choose the largest f in 7..0 such that (acc >>> (7 − f)) lies in [−4096, 4095]. The shift is arithmetic, so rounding is toward −∞.
  - out_data = {f[2:0], (acc >>> (7 − f))[12:0]}.
  - If no f fits, or sticky_ovf = 1: out_data = 16'h0000, out_overflow = 1.
  - Go to DONE with out_valid = 1.
- DONE:
  - in_ready = 0; out_data / out_overflow held stable while out_valid & !out_ready.
  - On out_ready: out_valid = 0; acc, sticky_ovf and term_count clear; return to ACCUM.
  - in_ready rises in the cycle after the handshake.

Timing and boundary cases:
- Latency: term with in_last accepted at edge t → out_valid high after edge t+2. Throughput is one term per cycle in ACCUM.
- A zero sum normalizes to F = 7, M = 0 (16'hE000).
- A group of a single term is legal.
- in_valid while in_ready = 0 is ignored; the upstream source must hold its data.
- term_count remains readable until the DONE handshake completes.

Test Plan:
- Single term: in_data 16'b000_0000000000010 (2), in_last → out_data 16'b111_0000100000000 (M = 256, F = 7), out_overflow 0; out_valid exactly 2 edges after acceptance.
- Mixed formats:
  - Terms 16'b001_0000000000111 (3.5) then 16'b100_0000001010100 (5.25, in_last) → sum 8.75, out_data {3'b111, 13'd1120}.
  - Terms −26 then 28.15625 (16'b101_0001110000101) → {3'b111, 13'd276}.
- Normalization down-shift: two terms 16'b000_0000001100100 (100) → 200; out_data 16'b100_0110010000000 (F = 4, M = 3200).
  - Two terms 4095 (F = 0) → out_data 0, out_overflow 1.
- Sticky overflow: three terms, the second with in_overflow = 1 → out_data 16'h0000, out_overflow 1.
  - Also feed 16 terms without in_last, the 16th carrying in_last → out_overflow 1.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles → out_data stable, in_ready 0, extra in_valid pulses ignored.
  - Assert rst after 2 of 3 terms → all outputs zero, term_count 0, next group sums from zero.

Source files
------------

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Purpose:
//   Sits directly behind multiplier_16bit in the ODE datapath. It sums a group
//   of tagged fixed-point products (for example h*k1 + h*k2 + ... for one
//   solver step). It then re-normalizes the sum into the same tagged format,
//   using the highest precision that still fits. The overflow convention
//   matches the multiplier: when out_overflow_o is 1, out_data_o is 0.
//
//   Tagged format: [15:13] = F (fraction bits, 0..7)
//                  [12:0]  = signed mantissa M
//                  value   = M / 2^F
//
// Ports:
//   clk_i          single clock, all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   in_valid_i     in_data_i / in_overflow_i / in_last_i are valid
//   in_ready_o     a term is accepted this cycle (only in ACCUM)
//   in_data_i      16-bit tagged product
//   in_overflow_i  multiplier overflow flag for this product
//   in_last_i      final term of the current group
//   out_valid_o    normalized sum is available
//   out_ready_i    consumer takes the sum
//   out_data_o     sum in tagged format (0 when out_overflow_o is set)
//   out_overflow_o sum is invalid
//   term_count_o   terms accepted in the current group (saturating)
//
// Parameters:
//   MAX_TERMS  maximum number of products per group
//   CNT_W      term counter width, 2^CNT_W > MAX_TERMS
//   ACC_W      accumulator width, >= 20 + ceil(log2(MAX_TERMS+1)), so a
//              legal group can never wrap the accumulator
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int MAX_TERMS = 15,
    parameter int CNT_W     = 4,
    parameter int ACC_W     = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_data_i,
    input  logic             in_overflow_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [15:0]      out_data_o,
    output logic             out_overflow_o,
    output logic [CNT_W-1:0] term_count_o
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        NORM  = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] MANT_MIN = ACC_W'(-4096);
    localparam logic signed [ACC_W-1:0] MANT_MAX = ACC_W'(4095);
    localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(MAX_TERMS);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     stickyOvf_q, stickyOvf_d;
    logic [CNT_W-1:0]         termCount_q, termCount_d;
    logic [15:0]              outData_q, outData_d;
    logic                     outOverflow_q, outOverflow_d;
    logic                     outValid_q, outValid_d;

    logic [ACC_W-1:0]         mantExt;
    logic signed [ACC_W-1:0]  alignedTerm;
    logic signed [ACC_W-1:0]  shifted;
    logic                     normFound;
    logic [2:0]               normF;
    logic [12:0]              normMant;

    // Every incoming term is brought to a common scale of 7 fraction bits.
    // The sign-extended mantissa is shifted left by (7 - F). The result is
    // always exact, because a 13-bit mantissa shifted by at most 7 needs
    // only 20 bits.
    always_comb begin
        mantExt     = {{(ACC_W-13){in_data_i[12]}}, in_data_i[12:0]};
        alignedTerm = mantExt <<< (3'd7 - in_data_i[15:13]);
    end

    // Normalization search. The loop walks f upward and keeps the last f
    // that fits, which gives the largest fitting f. A smaller f shifts
    // further right, so if any f fits, f = 0 fits too. The shift is
    // arithmetic, so a discarded remainder rounds toward minus infinity.
    always_comb begin
        normFound = 1'b0;
        normF     = 3'd0;
        normMant  = 13'd0;
        shifted   = '0;
        for (int f = 0; f < 8; f++) begin
            shifted = acc_q >>> (7 - f);
            if ((shifted >= MANT_MIN) && (shifted <= MANT_MAX)) begin
                normFound = 1'b1;
                normF     = 3'(f);
                normMant  = shifted[12:0];
            end
        end
    end

    // Next-state and datapath update.
    // ACCUM takes one term per cycle. A term that would push the count
    // past MAX_TERMS poisons the group through the sticky overflow flag.
    // NORM registers the normalized result.
    // DONE first raises out_valid_o from a flop, so the output data and
    // the valid flag both leave the block straight from registers. DONE
    // then waits for the consumer handshake and clears the group state.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        stickyOvf_d   = stickyOvf_q;
        termCount_d   = termCount_q;
        outData_d     = outData_q;
        outOverflow_d = outOverflow_q;
        outValid_d    = outValid_q;

        case (state_q)
            ACCUM: begin
                if (in_valid_i) begin
                    acc_d       = acc_q + alignedTerm;
                    stickyOvf_d = stickyOvf_q | in_overflow_i | (termCount_q == CNT_MAX);
                    if (termCount_q != CNT_MAX) begin
                        termCount_d = termCount_q + CNT_W'(1);
                    end
                    if (in_last_i) begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (!normFound || stickyOvf_q) begin
                    outData_d     = 16'h0000;
                    outOverflow_d = 1'b1;
                end else begin
                    outData_d     = {normF, normMant};
                    outOverflow_d = 1'b0;
                end
                state_d = DONE;
            end

            DONE: begin
                if (!outValid_q) begin
                    outValid_d = 1'b1;
                end else if (out_ready_i) begin
                    outValid_d    = 1'b0;
                    acc_d         = '0;
                    stickyOvf_d   = 1'b0;
                    termCount_d   = '0;
                    outData_d     = 16'h0000;
                    outOverflow_d = 1'b0;
                    state_d       = ACCUM;
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State register. Reset throws away any partial group or pending
    // result, so nothing is emitted for a group that reset interrupted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ACCUM;
            acc_q         <= '0;
            stickyOvf_q   <= 1'b0;
            termCount_q   <= '0;
            outData_q     <= 16'h0000;
            outOverflow_q <= 1'b0;
            outValid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            stickyOvf_q   <= stickyOvf_d;
            termCount_q   <= termCount_d;
            outData_q     <= outData_d;
            outOverflow_q <= outOverflow_d;
            outValid_q    <= outValid_d;
        end
    end

    // Output mapping.
    always_comb begin
        in_ready_o     = (state_q == ACCUM);
        out_valid_o    = outValid_q;
        out_data_o     = outData_q;
        out_overflow_o = outOverflow_q;
        term_count_o   = termCount_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Self-checking bench for product_accumulator. Groups of tagged products are
// sent to the design. The expected sum is computed with plain integer
// arithmetic from the group held in a queue:
//   - the sum is taken as sum(M * 2^(7-F));
//   - the result is renormalized by floor division;
//   - the overflow rules are applied.
// The bench then compares out_data, out_overflow, term_count and the
// handshake timing against these expected values.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [15:0] inData;
    logic        inOverflow;
    logic        inLast;
    logic        outValid;
    logic        outReady;
    logic [15:0] outData;
    logic        outOverflow;
    logic [3:0]  termCount;

    int          errors = 0;
    int          checks = 0;

    logic [15:0] grpData[$];
    bit          grpOvf[$];

    product_accumulator dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (inValid),
        .in_ready_o     (inReady),
        .in_data_i      (inData),
        .in_overflow_i  (inOverflow),
        .in_last_i      (inLast),
        .out_valid_o    (outValid),
        .out_ready_i    (outReady),
        .out_data_o     (outData),
        .out_overflow_o (outOverflow),
        .term_count_o   (termCount)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point. Every check is counted here, and any
    // disagreement is reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Builds a tagged word from a fraction count and a signed mantissa.
    function automatic logic [15:0] mkTerm(input int f, input int m);
        logic [15:0] r;
        r = {3'(f), 13'(m)};
        return r;
    endfunction

    // Reference model. It sums the group exactly as rational numbers on a
    // 1/128 grid. It then picks the largest fraction count whose
    // floor-divided mantissa fits in 13 signed bits.
    task automatic modelGroup(output logic [15:0] expData, output bit expOvf, output int expCnt);
        longint sum;
        longint q;
        longint d;
        int     mval;
        int     fval;
        int     fsel;
        bit     ovf;
        bit     found;
        logic [2:0]  f3;
        logic [12:0] m13;
        sum   = 0;
        ovf   = 0;
        found = 0;
        fsel  = 0;
        q     = 0;
        m13   = '0;
        for (int i = 0; i < grpData.size(); i++) begin
            mval = $signed(grpData[i][12:0]);
            fval = int'(grpData[i][15:13]);
            sum  = sum + longint'(mval) * (longint'(1) << (7 - fval));
            ovf  = ovf | grpOvf[i];
        end
        if (grpData.size() > 15) ovf = 1;
        expCnt = (grpData.size() > 15) ? 15 : grpData.size();
        for (int f = 7; f >= 0; f--) begin
            d = longint'(1) << (7 - f);
            q = sum / d;
            if ((sum % d != 0) && (sum < 0)) q = q - 1;
            if (q >= -4096 && q <= 4095) begin
                found = 1;
                fsel  = f;
                m13   = q[12:0];
                break;
            end
        end
        f3 = fsel[2:0];
        if (!found || ovf) begin
            expData = 16'h0000;
            expOvf  = 1;
        end else begin
            expData = {f3, m13};
            expOvf  = 0;
        end
    endtask

    // Presents one term and holds it until the design accepts it. Returns
    // 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [15:0] data, input bit ovf, input bit last);
        inValid    = 1'b1;
        inData     = data;
        inOverflow = ovf;
        inLast     = last;
        for (int k = 0; k < 20; k++) begin
            if (inReady) break;
            @(posedge clk); #1;
        end
        checkOutput("in_ready_wait", inReady, 1);
        @(posedge clk); #1;
        inValid    = 1'b0;
        inLast     = 1'b0;
        inOverflow = 1'b0;
        inData     = 16'($urandom);
    endtask

    // Sends the queued group with optional idle gaps between terms. It
    // checks latency, result, backpressure hold and the output handshake.
    // When usePlan is set, the result is also compared with a known
    // constant.
    task automatic runGroup(input int maxGap, input int bpCycles,
                            input bit usePlan, input logic [16:0] planExp);
        logic [15:0] expData;
        bit          expOvf;
        int          expCnt;
        modelGroup(expData, expOvf, expCnt);
        for (int i = 0; i < grpData.size(); i++) begin
            if (maxGap > 0) begin
                repeat ($urandom_range(0, maxGap)) begin
                    @(posedge clk); #1;
                end
            end
            applyStimulus(grpData[i], grpOvf[i], i == grpData.size() - 1);
        end
        checkOutput("valid_t0", outValid, 0);
        checkOutput("ready_norm", inReady, 0);
        @(posedge clk); #1;
        checkOutput("valid_t1", outValid, 0);
        @(posedge clk); #1;
        checkOutput("valid_t2", outValid, 1);
        checkOutput("out_data", outData, expData);
        checkOutput("out_overflow", outOverflow, expOvf);
        checkOutput("term_count", termCount, expCnt);
        if (usePlan) begin
            checkOutput("plan_result", {outOverflow, outData}, planExp);
        end
        for (int k = 0; k < bpCycles; k++) begin
            outReady   = 1'b0;
            inValid    = 1'($urandom);
            inLast     = 1'b1;
            inOverflow = 1'($urandom);
            inData     = 16'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_valid", outValid, 1);
            checkOutput("bp_data", outData, expData);
            checkOutput("bp_ovf", outOverflow, expOvf);
            checkOutput("bp_ready", inReady, 0);
            checkOutput("bp_count", termCount, expCnt);
        end
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("post_valid", outValid, 0);
        checkOutput("post_ready", inReady, 1);
        checkOutput("post_count", termCount, 0);
        grpData.delete();
        grpOvf.delete();
    endtask

    // Pulses reset for one cycle and checks that every output is cleared.
    task automatic pulseReset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput({tag, "_valid"}, outValid, 0);
        checkOutput({tag, "_data"}, outData, 0);
        checkOutput({tag, "_ovf"}, outOverflow, 0);
        checkOutput({tag, "_count"}, termCount, 0);
        checkOutput({tag, "_ready"}, inReady, 1);
    endtask

    // Main sequence: directed cases first, then randomized groups.
    initial begin
        int n;
        rst        = 1'b1;
        inValid    = 1'b0;
        inData     = 16'h0000;
        inOverflow = 1'b0;
        inLast     = 1'b0;
        outReady   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulseReset("reset");

        grpData.push_back(16'b000_0000000000010); grpOvf.push_back(0);
        runGroup(0, 0, 1, {1'b0, 16'b111_0000100000000});

        grpData.push_back(16'b001_0000000000111); grpOvf.push_back(0);
        grpData.push_back(16'b100_0000001010100); grpOvf.push_back(0);
        runGroup(0, 0, 1, {1'b0, 3'b111, 13'd1120});

        grpData.push_back(mkTerm(0, -26));        grpOvf.push_back(0);
        grpData.push_back(16'b101_0001110000101); grpOvf.push_back(0);
        runGroup(0, 0, 1, {1'b0, 3'b111, 13'd276});

        grpData.push_back(16'b000_0000001100100); grpOvf.push_back(0);
        grpData.push_back(16'b000_0000001100100); grpOvf.push_back(0);
        runGroup(0, 0, 1, {1'b0, 16'b100_0110010000000});

        grpData.push_back(mkTerm(0, 4095)); grpOvf.push_back(0);
        grpData.push_back(mkTerm(0, 4095)); grpOvf.push_back(0);
        runGroup(0, 0, 1, {1'b1, 16'h0000});

        grpData.push_back(mkTerm(2, 5));  grpOvf.push_back(0);
        grpData.push_back(mkTerm(6, -5 * 16)); grpOvf.push_back(0);
        runGroup(1, 0, 1, {1'b0, 16'hE000});

        grpData.push_back(mkTerm(1, 3)); grpOvf.push_back(0);
        grpData.push_back(mkTerm(2, 7)); grpOvf.push_back(1);
        grpData.push_back(mkTerm(3, 9)); grpOvf.push_back(0);
        runGroup(0, 0, 1, {1'b1, 16'h0000});

        for (int i = 0; i < 16; i++) begin
            grpData.push_back(mkTerm($urandom_range(0, 7), $urandom_range(0, 200)));
            grpOvf.push_back(0);
        end
        runGroup(0, 0, 1, {1'b1, 16'h0000});

        grpData.push_back(mkTerm(3, -1000)); grpOvf.push_back(0);
        grpData.push_back(mkTerm(5, 777));   grpOvf.push_back(0);
        runGroup(0, 5, 0, 17'h0);

        applyStimulus(mkTerm(0, 50), 0, 0);
        applyStimulus(mkTerm(0, 60), 0, 0);
        checkOutput("mid_count", termCount, 2);
        pulseReset("rst_mid");
        grpData.push_back(mkTerm(0, 3)); grpOvf.push_back(0);
        runGroup(0, 0, 1, {1'b0, 3'b111, 13'd384});

        applyStimulus(mkTerm(4, 33), 0, 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre_rst_valid", outValid, 1);
        pulseReset("rst_done");

        for (int g = 0; g < 40; g++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    grpData.push_back(16'($urandom));
                end else begin
                    grpData.push_back(mkTerm($urandom_range(0, 7), $urandom_range(0, 600) - 300));
                end
                grpOvf.push_back($urandom_range(0, 9) == 0);
            end
            runGroup(2, $urandom_range(0, 3), 0, 17'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
